cgra_power_sequencer: RTL and testbench
=======================================

Name: cgra_power_sequencer

Overview:
- Sequences the CGRA external subsystem through power-down and power-up.
- Drives, in a fixed order and with programmable delays: clock gate, isolation, logic reset, power switch and memory retention.
- Sits between the X-HEEP power-control requests and the CGRA wrapper's clock, reset, isolation and retention inputs.
- Replaces the static always-on tie-offs with a handshaked FSM that waits for the power switch acknowledge.

Parameters:
- CLK_CYCLES, default 4: wait cycles after each clock-gate change.
- ISO_CYCLES, default 4: wait cycles after isolation assert or release.
- RST_CYCLES, default 8: cycles reset is held with the clock running during power-up.
- ACK_TIMEOUT, default 255: maximum wait cycles for the switch acknowledge before flagging an error.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- pwr_down_req_i  in  1  level/pulse request to power down; sampled only in ON
- pwr_up_req_i  in  1  level/pulse request to power up; sampled only in OFF and DRAIN
- retain_i  in  1  keep CGRA memory banks retentive while off; sampled with pwr_down_req_i
- cgra_busy_i  in  1  CGRA executing or bus transaction outstanding
- switch_ack_ni  in  1  power switch acknowledge, active-low: 0 = rail on
- clkgate_en_no  out  1  0 = CGRA clock running
- powergate_switch_no  out  1  0 = rail switched on
- powergate_iso_no  out  1  0 = outputs isolated
- rst_no  out  1  0 = CGRA logic held in reset
- ram_retentive_no  out  1  0 = memory banks retentive
- state_o  out  4  current FSM state encoding
- busy_o  out  1  FSM in any state other than ON or OFF
- done_o  out  1  one-cycle pulse on entry to ON or OFF
- error_o  out  1  sticky ack timeout flag

Behaviour:
- Reset values: clkgate_en_no=0, powergate_switch_no=0, powergate_iso_no=1, rst_no=1, ram_retentive_no=1, state=ON, busy_o=0, done_o=0, error_o=0.
- Reset mid-sequence returns the block immediately to these values.
- Outputs are registered and change on the cycle the state is entered.
- One down-counter, width $clog2(max param + 1), is loaded on entry to each timed state. The state exits the cycle after the counter reads 0.
- A parameter of 0 gives a 1-cycle state.

Power-down path:
- ON: pwr_down_req_i=1 latches retain_i into ret_q, clears error_o, and goes to DRAIN.
- DRAIN: wait while cgra_busy_i=1, with no timeout.
  - pwr_up_req_i=1 in DRAIN aborts back to ON, with no done pulse and outputs unchanged.
  - If busy=0 and up=1 in the same cycle, the abort wins.
  - busy=0 and up=0 goes to CLK_OFF.
- CLK_OFF: clkgate_en_no=1, wait CLK_CYCLES, then go to ISO_ON.
- ISO_ON: powergate_iso_no=0, wait ISO_CYCLES, then go to RST_ON.
- RST_ON: rst_no=0 for 1 cycle, then go to SW_OFF.
- SW_OFF: powergate_switch_no=1 and ram_retentive_no=~ret_q.
  - Wait for switch_ack_ni=1, then go to OFF.
  - If ACK_TIMEOUT cycles elapse first, set error_o=1 and go to OFF anyway.
- OFF: hold all outputs and pulse done_o. pwr_up_req_i=1 clears error_o and goes to SW_ON.
  - pwr_down_req_i in OFF is ignored.

Power-up path:
- SW_ON: powergate_switch_no=0.
  - Wait for switch_ack_ni=0, or for the timeout, which sets error_o.
  - Then go to CLK_ON.
- CLK_ON: clkgate_en_no=0 and ram_retentive_no=1, with rst_no still 0.
  - Wait max(CLK_CYCLES, RST_CYCLES), then go to RST_OFF.
- RST_OFF: rst_no=1, wait ISO_CYCLES, then go to ISO_OFF.
- ISO_OFF: powergate_iso_no=1 for 1 cycle, then go to ON and pulse done_o.

Requests and encoding:
- Requests arriving in any state other than those listed above are dropped, not queued.
- If both requests are high in ON, only the down request is acted on. In OFF, only the up request is acted on.
- State encoding: ON=0, DRAIN=1, CLK_OFF=2, ISO_ON=3, RST_ON=4, SW_OFF=5, OFF=6, SW_ON=7, CLK_ON=8, RST_OFF=9, ISO_OFF=10.
- Any illegal encoding goes to ON.

Test Plan:
- Full down, default parameters, cgra_busy_i=0, ack returns 3 cycles after switch release:
  - clkgate_en_no rises at t+2.
  - iso_no falls at t+7.
  - rst_no falls at t+12.
  - switch_no rises at t+13.
  - OFF at t+17 with a done pulse.
  - ram_retentive_no stays 1 since retain_i=0.
- Down with retain_i=1, then up:
  - ram_retentive_no=0 throughout OFF.
  - On up: switch_no=0; after ack=0, clkgate_en_no=0, ret_no=1 and rst_no=0 for 8 cycles.
  - Then rst_no=1, 4 cycles later iso_no=1, and ON with done_o pulsed.
- Drain abort: down request while cgra_busy_i=1 for 10 cycles, up request at cycle 5:
  - Returns to ON.
  - clkgate_en_no never toggles and done_o stays 0.
- Ack timeout: switch_ack_ni held at 0 through SW_OFF:
  - After 255 cycles, error_o=1 and state OFF.
  - The next up request clears error_o.
- Simultaneous and ignored requests:
  - Both requests in ON for 1 cycle: goes to DRAIN.
  - Down request in OFF: no change.
  - Up request during CLK_OFF: ignored, and the sequence completes to OFF.
- Async reset asserted in ISO_ON: outputs return to their reset values immediately; state_o=0 and error_o=0.

Source files
------------

// File: rtl/cgra_power_sequencer.sv
// CGRA power sequencer: orders clock gate, isolation, reset, power switch
// and retention through power-down and power-up with a switch handshake.
module cgra_power_sequencer #(
   parameter int CLK_CYCLES  = 4,
   parameter int ISO_CYCLES  = 4,
   parameter int RST_CYCLES  = 8,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       pwr_down_req_i,
   input  logic       pwr_up_req_i,
   input  logic       retain_i,
   input  logic       cgra_busy_i,
   input  logic       switch_ack_ni,
   output logic       clkgate_en_no,
   output logic       powergate_switch_no,
   output logic       powergate_iso_no,
   output logic       rst_no,
   output logic       ram_retentive_no,
   output logic [3:0] state_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       error_o
);

   localparam int CR_CYCLES = (CLK_CYCLES > RST_CYCLES) ? CLK_CYCLES : RST_CYCLES;
   localparam int MAX_A = (CR_CYCLES > ISO_CYCLES) ? CR_CYCLES : ISO_CYCLES;
   localparam int MAX_P = (MAX_A > ACK_TIMEOUT) ? MAX_A : ACK_TIMEOUT;
   localparam int CW = (MAX_P < 1) ? 1 : $clog2(MAX_P + 1);

   localparam logic [CW-1:0] L_CLK = CW'(CLK_CYCLES);
   localparam logic [CW-1:0] L_ISO = CW'(ISO_CYCLES);
   localparam logic [CW-1:0] L_CR  = CW'(CR_CYCLES);
   localparam logic [CW-1:0] L_ACK = CW'(ACK_TIMEOUT);

   typedef enum logic [3:0] {
      S_ON      = 4'd0,
      S_DRAIN   = 4'd1,
      S_CLK_OFF = 4'd2,
      S_ISO_ON  = 4'd3,
      S_RST_ON  = 4'd4,
      S_SW_OFF  = 4'd5,
      S_OFF     = 4'd6,
      S_SW_ON   = 4'd7,
      S_CLK_ON  = 4'd8,
      S_RST_OFF = 4'd9,
      S_ISO_OFF = 4'd10
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ret_q, ret_d;
   logic          err_d;
   logic          clk_d, sw_d, iso_d, rst_d, ram_d;
   logic          busy_d, done_d;

   // Next-state, counter, retention latch and error flag.
   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
      ret_d   = ret_q;
      err_d   = error_o;
      case (state_q)
         S_ON: begin
            if (pwr_down_req_i) begin
               ret_d   = retain_i;
               err_d   = 1'b0;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pwr_up_req_i) begin
               state_d = S_ON;
            end else if (!cgra_busy_i) begin
               state_d = S_CLK_OFF;
               cnt_d   = L_CLK;
            end
         end
         S_CLK_OFF: begin
            if (cnt_q == '0) begin
               state_d = S_ISO_ON;
               cnt_d   = L_ISO;
            end
         end
         S_ISO_ON: begin
            if (cnt_q == '0) state_d = S_RST_ON;
         end
         S_RST_ON: begin
            state_d = S_SW_OFF;
            cnt_d   = L_ACK;
         end
         S_SW_OFF: begin
            if (switch_ack_ni) begin
               state_d = S_OFF;
            end else if (cnt_q == '0) begin
               err_d   = 1'b1;
               state_d = S_OFF;
            end
         end
         S_OFF: begin
            if (pwr_up_req_i) begin
               err_d   = 1'b0;
               state_d = S_SW_ON;
               cnt_d   = L_ACK;
            end
         end
         S_SW_ON: begin
            if (!switch_ack_ni) begin
               state_d = S_CLK_ON;
               cnt_d   = L_CR;
            end else if (cnt_q == '0) begin
               err_d   = 1'b1;
               state_d = S_CLK_ON;
               cnt_d   = L_CR;
            end
         end
         S_CLK_ON: begin
            if (cnt_q == '0) begin
               state_d = S_RST_OFF;
               cnt_d   = L_ISO;
            end
         end
         S_RST_OFF: begin
            if (cnt_q == '0) state_d = S_ISO_OFF;
         end
         S_ISO_OFF: begin
            state_d = S_ON;
         end
         default: begin
            state_d = S_ON;
         end
      endcase
   end

   // Output values for the state being entered, so they register with it.
   always_comb begin
      clk_d = 1'b0;
      sw_d  = 1'b0;
      iso_d = 1'b1;
      rst_d = 1'b1;
      ram_d = 1'b1;
      case (state_d)
         S_CLK_OFF: begin
            clk_d = 1'b1;
         end
         S_ISO_ON: begin
            clk_d = 1'b1;
            iso_d = 1'b0;
         end
         S_RST_ON: begin
            clk_d = 1'b1;
            iso_d = 1'b0;
            rst_d = 1'b0;
         end
         S_SW_OFF, S_OFF: begin
            clk_d = 1'b1;
            sw_d  = 1'b1;
            iso_d = 1'b0;
            rst_d = 1'b0;
            ram_d = ~ret_d;
         end
         S_SW_ON: begin
            clk_d = 1'b1;
            iso_d = 1'b0;
            rst_d = 1'b0;
            ram_d = ~ret_d;
         end
         S_CLK_ON: begin
            iso_d = 1'b0;
            rst_d = 1'b0;
         end
         S_RST_OFF: begin
            iso_d = 1'b0;
         end
         default: begin
            clk_d = 1'b0;
         end
      endcase
      busy_d = (state_d != S_ON) && (state_d != S_OFF);
      done_d = ((state_d == S_ON) && (state_q == S_ISO_OFF)) ||
               ((state_d == S_OFF) && (state_q == S_SW_OFF));
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q             <= S_ON;
         cnt_q               <= '0;
         ret_q               <= 1'b0;
         error_o             <= 1'b0;
         clkgate_en_no       <= 1'b0;
         powergate_switch_no <= 1'b0;
         powergate_iso_no    <= 1'b1;
         rst_no              <= 1'b1;
         ram_retentive_no    <= 1'b1;
         busy_o              <= 1'b0;
         done_o              <= 1'b0;
      end else begin
         state_q             <= state_d;
         cnt_q               <= cnt_d;
         ret_q               <= ret_d;
         error_o             <= err_d;
         clkgate_en_no       <= clk_d;
         powergate_switch_no <= sw_d;
         powergate_iso_no    <= iso_d;
         rst_no              <= rst_d;
         ram_retentive_no    <= ram_d;
         busy_o              <= busy_d;
         done_o              <= done_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_cgra_power_sequencer.sv
// Bench for cgra_power_sequencer: scripted power sequences push expected
// state entries; a monitor checks each entry's outputs and dwell time.
module tb_cgra_power_sequencer;

   localparam int ACK_TO = 255;

   logic       clk;
   logic       rst_n;
   logic       down, up, retain, busy, ack_n;
   logic       clkgate_en_no, switch_no, iso_no, rst_no, ram_no;
   logic [3:0] state;
   logic       busy_o, done_o, error_o;

   cgra_power_sequencer dut (
      .clk_i               (clk),
      .rst_ni              (rst_n),
      .pwr_down_req_i      (down),
      .pwr_up_req_i        (up),
      .retain_i            (retain),
      .cgra_busy_i         (busy),
      .switch_ack_ni       (ack_n),
      .clkgate_en_no       (clkgate_en_no),
      .powergate_switch_no (switch_no),
      .powergate_iso_no    (iso_no),
      .rst_no              (rst_no),
      .ram_retentive_no    (ram_no),
      .state_o             (state),
      .busy_o              (busy_o),
      .done_o              (done_o),
      .error_o             (error_o)
   );

   typedef struct {
      logic [3:0] st;
      logic [4:0] outs;
      logic       err;
      logic       done;
      int         dwell;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_cyc = 0;
   logic [3:0] prev_st = 4'd0;

   wire [4:0] outs = {clkgate_en_no, switch_no, iso_no, rst_no, ram_no};

   localparam logic [3:0] ON = 0, DRAIN = 1, CLK_OFF = 2, ISO_ON = 3;
   localparam logic [3:0] RST_ON = 4, SW_OFF = 5, OFF = 6, SW_ON = 7;
   localparam logic [3:0] CLK_ON = 8, RST_OFF = 9, ISO_OFF = 10;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every state entry must match the next scoreboard entry.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_st  = state;
         last_cyc = cyc;
      end else if (state !== prev_st) begin
         if (sb.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL unexpected_entry: got state %0d expected none", state);
         end else begin
            e = sb.pop_front();
            chk("state", int'(state), int'(e.st));
            chk($sformatf("outs_s%0d", e.st), int'(outs), int'(e.outs));
            chk($sformatf("error_s%0d", e.st), int'(error_o), int'(e.err));
            chk($sformatf("done_s%0d", e.st), int'(done_o), int'(e.done));
            if (e.dwell >= 0)
               chk($sformatf("dwell_before_s%0d", e.st), cyc - last_cyc, e.dwell);
         end
         prev_st  = state;
         last_cyc = cyc;
      end else if (done_o) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL done_held: got 1 expected 0 in state %0d", state);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] s, input logic [4:0] o,
                       input logic er, input logic dn, input int dw);
      exp_t e;
      e.st = s; e.outs = o; e.err = er; e.done = dn; e.dwell = dw;
      sb.push_back(e);
   endtask

   task automatic wait_state(input logic [3:0] s, input int budget);
      int n;
      n = 0;
      while (state !== s && n < budget) begin
         tick();
         n++;
      end
      if (state !== s) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL wait_state: got %0d expected %0d", state, s);
      end
   endtask

   task automatic do_down(input logic ret, input bit both, input bit up_mid,
                          input int ack_delay);
      logic [4:0] off_o;
      off_o = ret ? 5'b11000 : 5'b11001;
      push(DRAIN,   5'b00111, 1'b0, 1'b0, -1);
      push(CLK_OFF, 5'b10111, 1'b0, 1'b0, 1);
      push(ISO_ON,  5'b10011, 1'b0, 1'b0, 5);
      push(RST_ON,  5'b10001, 1'b0, 1'b0, 5);
      push(SW_OFF,  off_o,    1'b0, 1'b0, 1);
      push(OFF, off_o, (ack_delay < 0), 1'b1,
           (ack_delay < 0) ? ACK_TO + 1 : ack_delay + 1);
      retain = ret; down = 1'b1; up = both;
      tick();
      retain = 1'b0; down = 1'b0; up = 1'b0;
      if (up_mid) begin
         wait_state(CLK_OFF, 10);
         up = 1'b1;
         tick();
         up = 1'b0;
      end
      wait_state(SW_OFF, 40);
      if (ack_delay >= 0) begin
         repeat (ack_delay) tick();
         ack_n = 1'b1;
      end
      wait_state(OFF, 400);
   endtask

   task automatic do_up(input logic ret);
      ack_n = 1'b1;
      push(SW_ON,   ret ? 5'b10000 : 5'b10001, 1'b0, 1'b0, -1);
      push(CLK_ON,  5'b00001, 1'b0, 1'b0, 3);
      push(RST_OFF, 5'b00011, 1'b0, 1'b0, 9);
      push(ISO_OFF, 5'b00111, 1'b0, 1'b0, 5);
      push(ON,      5'b00111, 1'b0, 1'b1, 1);
      up = 1'b1;
      tick();
      up = 1'b0;
      chk("switch_on_after_up", int'(switch_no), 0);
      tick();
      tick();
      ack_n = 1'b0;
      wait_state(ON, 40);
   endtask

   initial begin
      rst_n = 1'b0; down = 1'b0; up = 1'b0; retain = 1'b0;
      busy = 1'b0; ack_n = 1'b0;
      #12;
      chk("rst_state", int'(state), 0);
      chk("rst_outs", int'(outs), 5'b00111);
      chk("rst_flags", int'({busy_o, done_o, error_o}), 0);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("idle_state", int'(state), 0);

      // full power-down, no retention, ack 3 cycles after switch release
      do_down(1'b0, 1'b0, 1'b0, 3);
      chk("off_busy", int'(busy_o), 0);

      // down request while OFF is dropped
      down = 1'b1;
      tick();
      down = 1'b0;
      repeat (3) tick();
      chk("off_ignores_down", int'(state), int'(OFF));

      do_up(1'b0);

      // retentive power-down, then power-up
      do_down(1'b1, 1'b0, 1'b0, 3);
      repeat (5) tick();
      chk("ret_held_in_off", int'(ram_no), 0);
      do_up(1'b1);

      // drain abort: up request while CGRA still busy
      busy = 1'b1;
      push(DRAIN, 5'b00111, 1'b0, 1'b0, -1);
      push(ON,    5'b00111, 1'b0, 1'b0, 5);
      down = 1'b1;
      tick();
      down = 1'b0;
      chk("drain_busy", int'(busy_o), 1);
      repeat (4) tick();
      up = 1'b1;
      tick();
      up = 1'b0;
      repeat (5) tick();
      busy = 1'b0;
      repeat (3) tick();
      chk("abort_state", int'(state), int'(ON));

      // both requests in ON, then up during CLK_OFF is dropped
      do_down(1'b0, 1'b1, 1'b1, 2);
      do_up(1'b0);

      // switch never acknowledges power-off
      do_down(1'b0, 1'b0, 1'b0, -1);
      chk("timeout_error", int'(error_o), 1);
      do_up(1'b0);
      chk("error_cleared", int'(error_o), 0);

      // async reset in the middle of the power-down sequence
      push(DRAIN,   5'b00111, 1'b0, 1'b0, -1);
      push(CLK_OFF, 5'b10111, 1'b0, 1'b0, 1);
      push(ISO_ON,  5'b10011, 1'b0, 1'b0, 5);
      down = 1'b1;
      tick();
      down = 1'b0;
      wait_state(ISO_ON, 20);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_state", int'(state), 0);
      chk("arst_outs", int'(outs), 5'b00111);
      chk("arst_flags", int'({busy_o, done_o, error_o}), 0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      repeat (4) tick();
      chk("post_arst_state", int'(state), 0);

      chk("scoreboard_left", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
